timer: RTL and testbench
========================

TIMER -- requirements
Module: timer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port addr, input, 2 bits: register select (0 CTRL, 1 PRESCALE, 2 PERIOD, 3 COUNT).
REQ-004 SHALL have port wr_en, input, 1 bit: write strobe; the write takes effect at the clock edge.
REQ-005 SHALL have port wr_data, input, 8 bits: write data.
REQ-006 SHALL have port rd_data, output, 8 bits: combinational read of the register selected by addr.
REQ-007 SHALL have port int_hold, input, 1 bit: interrupt controller is clearing status; defers delivery.
REQ-008 SHALL have port timer_interrupt, output, 1 bit: single-cycle interrupt request to the interrupt controller.

Function
REQ-009 SHALL implement CTRL with these bits: bit0 EN, bit1 AR (auto-reload), bit2 IE, bit7 OVR (sticky overrun, read-only); bits 6:3 read 0.
REQ-010 SHALL clear the 8-bit prescaler counter whenever EN=0.
REQ-011 SHALL, while EN=1, increment the prescaler counter each cycle, and when it equals PRESCALE, reset it to 0 and assert an internal tick for that cycle, giving a tick every PRESCALE+1 cycles.
REQ-012 SHALL, on a tick, compare COUNT to PERIOD: if equal, set COUNT to 0 and raise expiry; otherwise increment COUNT mod 256 (no expiry on 255->0 wrap).
REQ-013 SHALL make PERIOD=0 raise expiry on every tick.
REQ-014 SHALL, on expiry with AR=0, clear EN in the same edge (one-shot); with AR=1, leave EN set.
REQ-015 SHALL, on expiry with IE=1 (value before the edge), set the pending flag.
REQ-016 SHALL, on expiry while pending is already set, keep pending set and set OVR.
REQ-017 SHALL drive timer_interrupt = pending AND NOT int_hold (combinational).
REQ-018 SHALL clear pending at the edge of any cycle in which timer_interrupt=1, unless a new expiry occurs in that same cycle, in which case pending stays set.
REQ-019 SHALL keep pending set while int_hold=1 and deliver the request in the first cycle with int_hold=0.
REQ-020 SHALL, on a CTRL write, load EN/AR/IE from wr_data[2:0], clear OVR, and clear the prescaler counter; this overrides one-shot EN clearing in the same cycle.
REQ-021 SHALL, on a COUNT write, load COUNT and clear the prescaler counter; a tick in the same cycle is suppressed (no increment, no expiry).
REQ-022 SHALL load PRESCALE and PERIOD on write without disturbing running counters; a new PRESCALE below the current prescaler value leaves the counter to wrap through 255.
REQ-023 SHALL not change pending when CTRL is written with IE=0.

Reset
REQ-024 SHALL, on rst=1, set CTRL=0, PRESCALE=0, PERIOD=0, COUNT=0, prescaler=0 and pending=0, and drive timer_interrupt=0 from the next cycle on; rst overrides all writes and events.
REQ-025 SHALL let rst asserted mid-count or mid-hold discard pending requests, with no interrupt emitted afterward.

Verification
REQ-026 SHALL be verified by: PRESCALE=3, PERIOD=2, CTRL=0x07 -> timer_interrupt pulses exactly 1 cycle every 12 cycles; COUNT reads 0,1,2 in sequence.
REQ-027 SHALL be verified by: CTRL=0x05 (one-shot), PERIOD=4, PRESCALE=0 -> a single pulse 5 cycles after the write, then CTRL reads 0x04 and no further pulses.
REQ-028 SHALL be verified by: expiry while int_hold=1 for 3 cycles -> no pulse during hold; a 1-cycle pulse in the first cycle int_hold=0.
REQ-029 SHALL be verified by: PERIOD=0, PRESCALE=0, int_hold held high -> second expiry sets OVR (CTRL reads 0x87); a CTRL write of 0x07 clears OVR.
REQ-030 SHALL be verified by: COUNT written to 200 with PERIOD=5 -> COUNT wraps 255->0 with no pulse, and the pulse occurs on the tick where COUNT equals 5.
REQ-031 SHALL be verified by: rst asserted while pending=1 -> timer_interrupt=0 and all registers read 0 on the next cycle.

Source files
------------

// File: rtl/timer.sv
// ---------------------------------------------------------------------------
// timer
//
// Prescaled 8-bit interval timer with a small register file and a
// single-cycle interrupt request towards an interrupt controller.
//
// Register map (addr):
//   0 CTRL     : bit0 EN, bit1 AR (auto-reload), bit2 IE, bit7 OVR (read-only)
//   1 PRESCALE : tick every PRESCALE+1 enabled cycles
//   2 PERIOD   : COUNT value at which a tick raises expiry
//   3 COUNT    : current tick count
//
// Ports:
//   clk             - clock, all state updates on the rising edge
//   rst             - synchronous active-high reset
//   addr            - register select
//   wr_en           - write strobe, write lands at the clock edge
//   wr_data         - write data
//   rd_data         - combinational read of the register selected by addr
//   int_hold        - interrupt controller busy, defers delivery
//   timer_interrupt - single-cycle interrupt request
// ---------------------------------------------------------------------------
module timer (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] addr,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  input  logic       int_hold,
  output logic       timer_interrupt
);

  logic       en_q, en_d;
  logic       autoReload_q, autoReload_d;
  logic       intEnable_q, intEnable_d;
  logic       overrun_q, overrun_d;
  logic [7:0] prescale_q, prescale_d;
  logic [7:0] period_q, period_d;
  logic [7:0] count_q, count_d;
  logic [7:0] presCnt_q, presCnt_d;
  logic       pending_q, pending_d;

  logic ctrlWr, prescaleWr, periodWr, countWr;
  logic tick, expiry;

  assign ctrlWr     = wr_en && (addr == 2'd0);
  assign prescaleWr = wr_en && (addr == 2'd1);
  assign periodWr   = wr_en && (addr == 2'd2);
  assign countWr    = wr_en && (addr == 2'd3);

  // A COUNT write owns the counter for that cycle, so it swallows the tick.
  assign tick   = en_q && (presCnt_q == prescale_q) && !countWr;
  assign expiry = tick && (count_q == period_q);

  assign timer_interrupt = pending_q && !int_hold;

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      2'd0: rd_data = {overrun_q, 4'b0000, intEnable_q, autoReload_q, en_q};
      2'd1: rd_data = prescale_q;
      2'd2: rd_data = period_q;
      2'd3: rd_data = count_q;
      default: rd_data = 8'h00;
    endcase
  end

  always_comb begin
    en_d         = en_q;
    autoReload_d = autoReload_q;
    intEnable_d  = intEnable_q;
    overrun_d    = overrun_q;
    prescale_d   = prescale_q;
    period_d     = period_q;
    count_d      = count_q;
    presCnt_d    = presCnt_q;
    pending_d    = pending_q;

    // Prescaler compares for equality only, so a PRESCALE lowered below the
    // running value lets the counter wrap through 255 before matching.
    if (!en_q || ctrlWr || countWr) begin
      presCnt_d = 8'h00;
    end else if (presCnt_q == prescale_q) begin
      presCnt_d = 8'h00;
    end else begin
      presCnt_d = presCnt_q + 8'd1;
    end

    if (countWr) begin
      count_d = wr_data;
    end else if (tick) begin
      count_d = expiry ? 8'h00 : count_q + 8'd1;
    end

    // A CTRL write in the same cycle as a one-shot expiry keeps the
    // software-written EN value.
    if (ctrlWr) begin
      en_d         = wr_data[0];
      autoReload_d = wr_data[1];
      intEnable_d  = wr_data[2];
    end else if (expiry && !autoReload_q) begin
      en_d = 1'b0;
    end

    if (ctrlWr) begin
      overrun_d = 1'b0;
    end else if (expiry && pending_q) begin
      overrun_d = 1'b1;
    end

    // A fresh expiry beats delivery, so a request arriving in the delivery
    // cycle is not lost.
    if (expiry && (intEnable_q || pending_q)) begin
      pending_d = 1'b1;
    end else if (timer_interrupt) begin
      pending_d = 1'b0;
    end

    if (prescaleWr) prescale_d = wr_data;
    if (periodWr)   period_d   = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q         <= 1'b0;
      autoReload_q <= 1'b0;
      intEnable_q  <= 1'b0;
      overrun_q    <= 1'b0;
      prescale_q   <= 8'h00;
      period_q     <= 8'h00;
      count_q      <= 8'h00;
      presCnt_q    <= 8'h00;
      pending_q    <= 1'b0;
    end else begin
      en_q         <= en_d;
      autoReload_q <= autoReload_d;
      intEnable_q  <= intEnable_d;
      overrun_q    <= overrun_d;
      prescale_q   <= prescale_d;
      period_q     <= period_d;
      count_q      <= count_d;
      presCnt_q    <= presCnt_d;
      pending_q    <= pending_d;
    end
  end

endmodule

// File: tb/tb_timer.sv
// ---------------------------------------------------------------------------
// tb_timer
//
// Directed bench for timer: a table of register/one-shot vectors followed by
// hand-written sequences for periodic interrupts, held delivery, overrun,
// reset while pending, count wrap and COUNT-write tick suppression.
// ---------------------------------------------------------------------------
module tb_timer;

  logic       clk;
  logic       rst;
  logic [1:0] addr;
  logic       wr_en;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       int_hold;
  logic       timer_interrupt;

  int checkCount;
  int passCount;

  typedef struct {
    logic       wr;
    logic [1:0] a;
    logic [7:0] d;
    logic       hold;
    logic [7:0] expRd;
    logic       expIrq;
  } vec_t;

  vec_t vecs[22];

  timer dut (
    .clk             (clk),
    .rst             (rst),
    .addr            (addr),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .rd_data         (rd_data),
    .int_hold        (int_hold),
    .timer_interrupt (timer_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Drive one vector, clock it, then leave the write strobe low so rd_data
  // shows the post-edge state of the selected register.
  task automatic applyStimulus(input vec_t v);
    addr     = v.a;
    wr_data  = v.d;
    wr_en    = v.wr;
    int_hold = v.hold;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [7:0] d);
    addr    = a;
    wr_data = d;
    wr_en   = 1'b1;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst      = 1'b1;
    wr_en    = 1'b0;
    int_hold = 1'b0;
    addr     = 2'd0;
    wr_data  = 8'h00;
    nextCycle();
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    rst        = 1'b1;
    wr_en      = 1'b0;
    addr       = 2'd0;
    wr_data    = 8'h00;
    int_hold   = 1'b0;

    // wr, addr, data, hold, expected read after edge, expected irq
    vecs[0]  = '{1'b0, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 2'd2, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 2'd1, 8'hA5, 1'b0, 8'hA5, 1'b0};
    vecs[5]  = '{1'b1, 2'd2, 8'h3C, 1'b0, 8'h3C, 1'b0};
    vecs[6]  = '{1'b1, 2'd3, 8'h77, 1'b0, 8'h77, 1'b0};
    vecs[7]  = '{1'b1, 2'd0, 8'hFF, 1'b0, 8'h07, 1'b0};
    vecs[8]  = '{1'b1, 2'd0, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[9]  = '{1'b0, 2'd3, 8'h00, 1'b0, 8'h77, 1'b0};
    // one-shot: PRESCALE=0, PERIOD=4, COUNT=0, CTRL=0x05
    vecs[10] = '{1'b1, 2'd1, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 2'd2, 8'h04, 1'b0, 8'h04, 1'b0};
    vecs[12] = '{1'b1, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[13] = '{1'b1, 2'd0, 8'h05, 1'b0, 8'h05, 1'b0};
    vecs[14] = '{1'b0, 2'd3, 8'h00, 1'b0, 8'h01, 1'b0};
    vecs[15] = '{1'b0, 2'd3, 8'h00, 1'b0, 8'h02, 1'b0};
    vecs[16] = '{1'b0, 2'd3, 8'h00, 1'b0, 8'h03, 1'b0};
    vecs[17] = '{1'b0, 2'd3, 8'h00, 1'b0, 8'h04, 1'b0};
    vecs[18] = '{1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[19] = '{1'b0, 2'd0, 8'h00, 1'b0, 8'h04, 1'b0};
    vecs[20] = '{1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[21] = '{1'b0, 2'd3, 8'h00, 1'b0, 8'h00, 1'b0};

    doReset();
    $display("[TB] register and one-shot vectors");
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d rd", i), rd_data, vecs[i].expRd);
      checkOutput($sformatf("vec%0d irq", i), {7'b0, timer_interrupt}, {7'b0, vecs[i].expIrq});
    end

    // Periodic: tick every 4 cycles, expiry every 3rd tick.
    doReset();
    $display("[TB] periodic auto-reload");
    writeReg(2'd1, 8'd3);
    writeReg(2'd2, 8'd2);
    writeReg(2'd0, 8'h07);
    addr = 2'd3;
    for (int k = 1; k <= 40; k++) begin
      nextCycle();
      checkOutput($sformatf("periodic irq k=%0d", k), {7'b0, timer_interrupt},
                  {7'b0, (k % 12) == 0});
      checkOutput($sformatf("periodic count k=%0d", k), rd_data, 8'((k / 4) % 3));
    end

    // Held delivery.
    doReset();
    $display("[TB] held delivery");
    writeReg(2'd2, 8'd1);
    writeReg(2'd0, 8'h05);
    nextCycle();
    checkOutput("hold pre irq", {7'b0, timer_interrupt}, 8'h00);
    int_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nextCycle();
      checkOutput($sformatf("hold irq %0d", k), {7'b0, timer_interrupt}, 8'h00);
    end
    int_hold = 1'b0;
    #1;
    checkOutput("hold release irq", {7'b0, timer_interrupt}, 8'h01);
    nextCycle();
    checkOutput("hold after irq", {7'b0, timer_interrupt}, 8'h00);
    addr = 2'd0;
    #1;
    checkOutput("hold ctrl oneshot", rd_data, 8'h04);

    // Overrun, back-to-back delivery, then reset while pending.
    doReset();
    $display("[TB] overrun and reset while pending");
    int_hold = 1'b1;
    writeReg(2'd0, 8'h07);
    nextCycle();
    nextCycle();
    checkOutput("ovr ctrl", rd_data, 8'h87);
    checkOutput("ovr irq held", {7'b0, timer_interrupt}, 8'h00);
    writeReg(2'd0, 8'h07);
    checkOutput("ovr cleared", rd_data, 8'h07);
    int_hold = 1'b0;
    #1;
    checkOutput("ovr release irq", {7'b0, timer_interrupt}, 8'h01);
    nextCycle();
    checkOutput("ovr irq kept", {7'b0, timer_interrupt}, 8'h01);
    int_hold = 1'b1;
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    int_hold = 1'b0;
    #1;
    checkOutput("rst irq", {7'b0, timer_interrupt}, 8'h00);
    for (int a = 0; a < 4; a++) begin
      addr = 2'(a);
      #1;
      checkOutput($sformatf("rst reg%0d", a), rd_data, 8'h00);
    end
    nextCycle();
    checkOutput("rst irq later", {7'b0, timer_interrupt}, 8'h00);

    // Count wrap 255->0 without expiry, expiry at PERIOD.
    doReset();
    $display("[TB] count wrap");
    writeReg(2'd2, 8'd5);
    writeReg(2'd3, 8'd200);
    writeReg(2'd0, 8'h07);
    addr = 2'd3;
    for (int k = 1; k <= 62; k++) begin
      nextCycle();
      checkOutput($sformatf("wrap irq k=%0d", k), {7'b0, timer_interrupt},
                  {7'b0, k == 62});
      checkOutput($sformatf("wrap count k=%0d", k), rd_data,
                  (k == 62) ? 8'h00 : 8'((200 + k) % 256));
    end

    // COUNT write suppresses the tick of its own cycle.
    nextCycle();
    nextCycle();
    checkOutput("sup pre count", rd_data, 8'h02);
    writeReg(2'd3, 8'd5);
    checkOutput("sup count", rd_data, 8'h05);
    checkOutput("sup irq", {7'b0, timer_interrupt}, 8'h00);
    nextCycle();
    checkOutput("sup expiry count", rd_data, 8'h00);
    checkOutput("sup expiry irq", {7'b0, timer_interrupt}, 8'h01);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
